// File: rtl/hero_write_collector.sv
// hero_write_collector: turns the sink side of the hero write bus (no
// backpressure) into a valid/ready beat stream with last/err markers.
// Overflow truncates the open transaction with an err terminator, or drops
// the whole transaction if nothing of it has been stored yet. Either way the
// consumer always sees a terminated transaction.
module hero_write_collector #(
  parameter int HERO_WIDTH = 36,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                hero_cycle_type,
  input  logic [HERO_WIDTH-1:0]     hero_wdat,
  input  logic                      hero_clk_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [HERO_WIDTH-1:0]     out_wdat,
  output logic                      out_last,
  output logic                      out_err,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [CNT_W-1:0]          txn_count,
  output logic                      err_overflow,
  output logic                      busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = HERO_WIDTH + 2;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_C   = CW'(2);
  localparam logic [CW-1:0] MAX_ACT = CW'(DEPTH - 1);

  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Beat storage: each entry is {wdat, last, err}
  logic [EW-1:0] mem [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  logic [AW:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count;
  logic [CW-1:0]   free;
  logic            empty;
  logic            pop;
  logic [EW-1:0]   head;

  logic            beat;
  logic            is_done;
  logic            room1;
  logic            room2;

  logic            push;
  logic [EW-1:0]   push_data;
  logic            txn_inc;
  logic            ovf_next;

  logic [CNT_W-1:0] txn_count_reg;
  logic             err_overflow_reg;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  // Space is judged on the pre-edge occupancy; a same-cycle pop does not help
  assign free    = DEPTH_C - count;
  assign room1   = (free != '0);
  assign room2   = (free >= TWO_C);

  assign beat    = hero_clk_en && ((hero_cycle_type == CT_VALID) ||
                                   (hero_cycle_type == CT_DONE));
  assign is_done = (hero_cycle_type == CT_DONE);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr_reg[AW-1:0]];

  // Show-ahead head; gated so an empty FIFO (including just after reset) presents zeros
  assign out_wdat  = out_valid ? head[EW-1:2] : '0;
  assign out_last  = out_valid ? head[1]      : 1'b0;
  assign out_err   = out_valid ? head[0]      : 1'b0;

  assign fifo_count   = count;
  assign txn_count    = txn_count_reg;
  assign err_overflow = err_overflow_reg;
  assign busy         = (state_reg != S_IDLE);

  // Transaction FSM: decides what (if anything) each bus beat pushes
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    push_data  = '0;
    txn_inc    = 1'b0;
    ovf_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (beat) begin
          if (is_done) begin
            if (room1) begin
              push      = 1'b1;
              push_data = {hero_wdat, 2'b10};
              txn_inc   = 1'b1;
            end else begin
              ovf_next  = 1'b1;
            end
          end else if (room2) begin
            // Leave a slot in reserve so a terminator can always be stored
            push       = 1'b1;
            push_data  = {hero_wdat, 2'b00};
            state_next = S_ACTIVE;
          end else begin
            // Nothing of this transaction stored yet, so drop it silently
            ovf_next   = 1'b1;
            state_next = S_DROP;
          end
        end
      end
      S_ACTIVE: begin
        if (beat) begin
          if (is_done) begin
            // The reserved slot guarantees room for the closing beat
            push       = 1'b1;
            push_data  = {hero_wdat, 2'b10};
            txn_inc    = 1'b1;
            state_next = S_IDLE;
          end else if (room2) begin
            push       = 1'b1;
            push_data  = {hero_wdat, 2'b00};
          end else begin
            // Close the stored part with an error terminator
            push       = 1'b1;
            push_data  = {{HERO_WIDTH{1'b0}}, 2'b11};
            ovf_next   = 1'b1;
            state_next = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (beat && is_done) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Storage array write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Good-transaction counter (wraps) and overflow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count_reg    <= '0;
      err_overflow_reg <= 1'b0;
    end else begin
      if (txn_inc) begin
        txn_count_reg <= txn_count_reg + 1'b1;
      end
      err_overflow_reg <= ovf_next;
    end
  end

  // An open transaction always keeps one slot free for its terminator
  a_active_room: assert property (@(posedge clk) disable iff (rst)
    (state_reg == S_ACTIVE) |-> (count <= MAX_ACT));

  // The FIFO is never written when full
  a_no_overwrite: assert property (@(posedge clk) disable iff (rst)
    push |-> (free != '0));

endmodule

// File: tb/tb_hero_write_collector.sv
// Bench for hero_write_collector: directed bus stimulus pushes the expected
// output entries into a queue; a negedge monitor pops and compares every
// accepted output beat. Directed checks cover counters, flags and busy.
module tb_hero_write_collector;

  localparam int HW    = 36;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam logic [1:0] CT_IDLE  = 2'd0;
  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;
  localparam logic [1:0] CT_RSVD  = 2'd3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       hero_cycle_type = CT_IDLE;
  logic [HW-1:0]    hero_wdat = '0;
  logic             hero_clk_en = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [HW-1:0]    out_wdat;
  logic             out_last;
  logic             out_err;
  logic [CW-1:0]    fifo_count;
  logic [CNT_W-1:0] txn_count;
  logic             err_overflow;
  logic             busy;

  hero_write_collector #(
    .HERO_WIDTH (HW),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hero_cycle_type (hero_cycle_type),
    .hero_wdat       (hero_wdat),
    .hero_clk_en     (hero_clk_en),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_wdat        (out_wdat),
    .out_last        (out_last),
    .out_err         (out_err),
    .fifo_count      (fifo_count),
    .txn_count       (txn_count),
    .err_overflow    (err_overflow),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  logic [HW+1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  // Scoreboard monitor: compare each accepted output beat against the queue
  always @(negedge clk) begin
    logic [HW+1:0] exp_e;
    logic [HW+1:0] got_e;
    if (!rst && out_valid && out_ready) begin
      got_e = {out_wdat, out_last, out_err};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got {wdat,last,err}=%h, required no output", got_e);
      end else begin
        exp_e = exp_q.pop_front();
        if (got_e !== exp_e) begin
          n_err++;
          $display("FAIL pop_data: got {wdat,last,err}=%h, required %h", got_e, exp_e);
        end else begin
          $display("pop ok: wdat=%h last=%0d err=%0d", out_wdat, out_last, out_err);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("check ok: %s = %0d", name, act);
    end
  endtask

  task automatic expect_beat(input logic [HW-1:0] d, input logic last, input logic err);
    exp_q.push_back({d, last, err});
  endtask

  // Drive one bus cycle; returns 1 time unit after the sampling edge
  task automatic cyc(input logic [1:0] ct, input logic [HW-1:0] d, input logic en);
    hero_cycle_type = ct;
    hero_wdat       = d;
    hero_clk_en     = en;
    @(posedge clk);
    #1;
    hero_cycle_type = CT_IDLE;
    hero_wdat       = '0;
    hero_clk_en     = 1'b0;
  endtask

  // Let the consumer empty the FIFO, bounded
  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (fifo_count == 0) break;
    end
    out_ready = 1'b0;
    check("drain_empty", int'(fifo_count), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_txn_count", int'(txn_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err_overflow", int'(err_overflow), 0);

    // 1: four-beat transaction with a ready consumer
    out_ready = 1'b1;
    expect_beat(36'h1, 1'b0, 1'b0);
    cyc(CT_VALID, 36'h1, 1'b1);
    check("t1_first_valid", int'(out_valid), 1);
    expect_beat(36'h2, 1'b0, 1'b0);
    cyc(CT_VALID, 36'h2, 1'b1);
    expect_beat(36'h3, 1'b0, 1'b0);
    cyc(CT_VALID, 36'h3, 1'b1);
    expect_beat(36'h4, 1'b1, 1'b0);
    cyc(CT_DONE, 36'h4, 1'b1);
    repeat (3) cyc(CT_IDLE, '0, 1'b1);
    out_ready = 1'b0;
    check("t1_txn_count", int'(txn_count), 1);
    check("t1_fifo_count", int'(fifo_count), 0);
    check("t1_busy", int'(busy), 0);

    // 2: ten-beat transaction, no consumer. Beats 1-7 fit (free>=2 up to count 6),
    //    beat 8 sees free=1 and becomes the terminator, beats 9-10 are discarded.
    for (int i = 1; i <= 9; i++) begin
      if (i <= 7) expect_beat(HW'(i), 1'b0, 1'b0);
      else if (i == 8) expect_beat('0, 1'b1, 1'b1);
      cyc(CT_VALID, HW'(i), 1'b1);
      if (i == 8) begin
        check("t2_ovf_pulse", int'(err_overflow), 1);
        check("t2_count_term", int'(fifo_count), 8);
        check("t2_busy_drop", int'(busy), 1);
      end
      if (i == 9) check("t2_ovf_single", int'(err_overflow), 0);
    end
    cyc(CT_DONE, 36'ha, 1'b1);
    check("t2_busy_idle", int'(busy), 0);
    check("t2_fifo_count", int'(fifo_count), 8);
    check("t2_txn_unchanged", int'(txn_count), 1);
    check("t2_no_pulse_done", int'(err_overflow), 0);
    drain();

    // 3: fill with single-beat transactions, then overflow from S_IDLE
    for (int i = 0; i < 8; i++) begin
      expect_beat(HW'(32'h30 + i), 1'b1, 1'b0);
      cyc(CT_DONE, HW'(32'h30 + i), 1'b1);
    end
    check("t3_full", int'(fifo_count), 8);
    check("t3_txn", int'(txn_count), 9);
    cyc(CT_DONE, 36'h99, 1'b1);
    check("t3_done_drop_pulse", int'(err_overflow), 1);
    check("t3_done_drop_count", int'(fifo_count), 8);
    check("t3_done_drop_idle", int'(busy), 0);
    check("t3_done_drop_txn", int'(txn_count), 9);
    cyc(CT_VALID, 36'h9a, 1'b1);
    check("t3_valid_drop_busy", int'(busy), 1);
    check("t3_valid_drop_count", int'(fifo_count), 8);
    check("t3_valid_drop_pulse", int'(err_overflow), 1);
    cyc(CT_DONE, 36'h9b, 1'b1);
    check("t3_exit_drop", int'(busy), 0);
    check("t3_exit_no_pulse", int'(err_overflow), 0);
    check("t3_exit_count", int'(fifo_count), 8);
    drain();

    // 4: gaps inside a transaction push nothing
    expect_beat(36'h41, 1'b0, 1'b0);
    cyc(CT_VALID, 36'h41, 1'b1);
    cyc(CT_IDLE, 36'h77, 1'b1);
    cyc(CT_VALID, 36'h55, 1'b0);
    cyc(CT_RSVD, 36'h66, 1'b1);
    check("t4_gap_busy", int'(busy), 1);
    expect_beat(36'h42, 1'b0, 1'b0);
    cyc(CT_VALID, 36'h42, 1'b1);
    expect_beat(36'h43, 1'b1, 1'b0);
    cyc(CT_DONE, 36'h43, 1'b1);
    check("t4_count", int'(fifo_count), 3);
    check("t4_txn", int'(txn_count), 10);
    drain();

    // 5: pop and push together at count 7; free is 1 so VALID terminates
    for (int i = 0; i < 7; i++) begin
      expect_beat(HW'(32'h50 + i), 1'b0, 1'b0);
      cyc(CT_VALID, HW'(32'h50 + i), 1'b1);
    end
    check("t5_count7", int'(fifo_count), 7);
    out_ready = 1'b1;
    expect_beat('0, 1'b1, 1'b1);
    cyc(CT_VALID, 36'h5f, 1'b1);
    out_ready = 1'b0;
    check("t5_count_same", int'(fifo_count), 7);
    check("t5_pulse", int'(err_overflow), 1);
    check("t5_busy_drop", int'(busy), 1);
    cyc(CT_DONE, 36'h5e, 1'b1);
    check("t5_idle", int'(busy), 0);
    check("t5_txn", int'(txn_count), 10);
    drain();

    // 6: reset in the middle of a transaction discards everything
    for (int i = 0; i < 3; i++) begin
      cyc(CT_VALID, HW'(32'h60 + i), 1'b1);
    end
    check("t6_count3", int'(fifo_count), 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_fifo_count", int'(fifo_count), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_txn", int'(txn_count), 0);
    expect_beat(36'habc, 1'b1, 1'b0);
    cyc(CT_DONE, 36'habc, 1'b1);
    check("t6_done_count", int'(fifo_count), 1);
    check("t6_done_txn", int'(txn_count), 1);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
